// File: rtl/foo_decode.sv
// foo_decode: recovers the per-cycle operands from an accumulated stream.
// Each input x[n+1] = x[n] + a[n] + 1 is turned back into a = x[n+1] - x[n] - 1.
// Results go into a small FIFO with valid/ready handshakes on both sides.
// Optional build macro FOO_DECODE_TRACE_EN prints decode and resync events.
module foo_decode #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [31:0]      in_x,
   output logic             in_ready,
   input  logic             resync,
   output logic             out_valid,
   output logic [31:0]      out_a,
   input  logic             out_ready,
   output logic [CNT_W-1:0] dec_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic {
      ST_SEED = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [31:0]             prev_q, prev_d;
   logic [DEPTH-1:0][31:0]  mem_q, mem_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]        occ_q, occ_d;
   logic [CNT_W-1:0]        dec_count_q, dec_count_d;

   logic                    full;
   logic                    accept;
   logic                    push;
   logic                    pop;
   logic [31:0]             diff;

   // Handshake decode; in_ready depends only on registered occupancy and resync,
   // so a pop in the same cycle never frees a slot early.
   always_comb begin
      full      = (occ_q == OCC_W'(DEPTH));
      in_ready  = !full && !resync;
      out_valid = (occ_q != '0);
      out_a     = mem_q[rd_ptr_q];
      dec_count = dec_count_q;
      accept    = in_valid && in_ready;
      push      = accept && (state_q == ST_RUN);
      pop       = out_valid && out_ready;
      diff      = in_x - prev_q - 32'd1;
   end

   // Next-state for the seed/run control, the previous sample and the FIFO.
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      occ_d       = occ_q;
      dec_count_d = dec_count_q;

      if (accept) begin
         prev_d  = in_x;
         state_d = ST_RUN;
      end
      // resync blocks acceptance, so it never competes with the load above
      if (resync) begin
         state_d = ST_SEED;
      end

      if (push) begin
         mem_d[wr_ptr_q] = diff;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         if (dec_count_q != '1) begin
            dec_count_d = dec_count_q + CNT_W'(1);
         end
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // State registers; reset clears everything, including FIFO storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_SEED;
         prev_q      <= '0;
         mem_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         dec_count_q <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         dec_count_q <= dec_count_d;
      end
   end

`ifdef FOO_DECODE_TRACE_EN
   initial $display("Starting up: %m");
   final   $display("All done: %m");

   // Event trace for decoded pushes and resync-driven returns to SEED.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         $display("%m: decoded a = %0d", diff);
      end
      if (rst_n && resync && state_q == ST_RUN) begin
         $display("%m: resync");
      end
   end
`endif

endmodule

// File: tb/tb_foo_decode.sv
// Directed bench for foo_decode: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares whenever the DUT pops an entry.
module tb_foo_decode;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_x = '0;
   logic        in_ready;
   logic        resync = 1'b0;
   logic        out_valid;
   logic [31:0] out_a;
   logic        out_ready = 1'b0;
   logic [15:0] dec_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   foo_decode #(.DEPTH(4), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_x      (in_x),
      .in_ready  (in_ready),
      .resync    (resync),
      .out_valid (out_valid),
      .out_a     (out_a),
      .out_ready (out_ready),
      .dec_count (dec_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: inputs change just after posedge, so at negedge a visible
   // out_valid && out_ready is exactly the pop the next edge performs.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got out_a 0x%0h expected no output", out_a);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (out_a !== e) begin
               errors++;
               $display("FAIL out_a: got 0x%0h expected 0x%0h", out_a, e);
            end
         end
      end
   end

   // Offer one beat and hold it until accepted (bounded).
   task automatic send(input logic [31:0] x, input bit seed, input logic [31:0] exp);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_x     = x;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 expected 1 for x=0x%0h", x);
      end else if (!seed) begin
         exp_q.push_back(exp);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_resync();
      resync = 1'b1;
      #1;
      chk("in_ready_during_resync", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      resync = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_a", out_a, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_dec_count", 32'(dec_count), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic decode
      out_ready = 1'b1;
      send(32'd0, 1'b1, 32'd0);
      chk("seed_no_output", 32'(out_valid), 32'd0);
      send(32'd6, 1'b0, 32'd5);
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      chk("latency_out_a", out_a, 32'd5);
      send(32'd12, 1'b0, 32'd5);
      send(32'd18, 1'b0, 32'd5);
      drain();
      chk("basic_dec_count", 32'(dec_count), 32'd3);

      // wrap-around
      pulse_resync();
      send(32'hFFFF_FFFE, 1'b1, 32'd0);
      send(32'h0000_0003, 1'b0, 32'd4);
      drain();

      // zero operand
      pulse_resync();
      send(32'd100, 1'b1, 32'd0);
      send(32'd101, 1'b0, 32'd0);
      drain();
      chk("zero_dec_count", 32'(dec_count), 32'd5);

      // backpressure
      out_ready = 1'b0;
      pulse_resync();
      send(32'd10, 1'b1, 32'd0);
      send(32'd20, 1'b0, 32'd9);
      send(32'd30, 1'b0, 32'd9);
      send(32'd40, 1'b0, 32'd9);
      send(32'd50, 1'b0, 32'd9);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_x     = 32'd60;
      exp_q.push_back(32'd9);
      repeat (3) @(posedge clk);
      #1;
      chk("held_in_ready", 32'(in_ready), 32'd0);
      chk("held_dec_count", 32'(dec_count), 32'd9);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("pop_no_same_push", 32'(dec_count), 32'd9);
      chk("after_pop_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("fifth_accepted", 32'(dec_count), 32'd10);
      out_ready = 1'b1;
      drain();
      chk("empty_out_valid", 32'(out_valid), 32'd0);

      // resync mid-stream
      pulse_resync();
      send(32'd0, 1'b1, 32'd0);
      send(32'd6, 1'b0, 32'd5);
      send(32'd12, 1'b0, 32'd5);
      pulse_resync();
      chk("resync_keeps_count", 32'(dec_count), 32'd12);
      send(32'd1000, 1'b1, 32'd0);
      @(posedge clk);
      #1;
      chk("resync_seed_no_push", 32'(dec_count), 32'd12);
      send(32'd1010, 1'b0, 32'd9);
      drain();
      chk("resync_dec_count", 32'(dec_count), 32'd13);

      // reset mid-stream
      out_ready = 1'b0;
      pulse_resync();
      send(32'd0, 1'b1, 32'd0);
      send(32'd6, 1'b0, 32'd5);
      send(32'd12, 1'b0, 32'd5);
      chk("two_queued_valid", 32'(out_valid), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_dec_count", 32'(dec_count), 32'd0);
      exp_q.delete();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'd50, 1'b1, 32'd0);
      send(32'd60, 1'b0, 32'd9);
      drain();
      chk("postrst_dec_count", 32'(dec_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/foo_decode.md
# foo_decode

Stream decoder that inverts the `foo_impl` accumulator. It consumes the sequence of accumulated values `x`, where each `x[n+1] = x[n] + a[n] + 1`, and recovers each `a` as `x[n+1] - x[n] - 1`. Recovered values are buffered in a small output FIFO with valid/ready handshakes on both sides. It sits on the consumer side of an accumulator link and returns the original per-cycle operands to downstream logic.

## Interface
Parameters:
- `DEPTH`, default 4: output FIFO entries; must be a power of 2, ≥2.
- `CNT_W`, default 16: width of `dec_count`.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `in_valid` input 1: `in_x` holds an accumulated value.
- `in_x` input 32: accumulated value.
- `in_ready` output 1: beat accepted when `in_valid && in_ready` at a rising edge.
- `resync` input 1: discard the seed and re-enter SEED.
- `out_valid` output 1: FIFO non-empty.
- `out_a` output 32: recovered operand at the FIFO head.
- `out_ready` input 1: head popped when `out_valid && out_ready` at a rising edge.
- `dec_count` output `CNT_W`: number of decoded values pushed; saturates at all-ones.

## Operation
- States:
  - SEED (reset state): an accepted beat loads `prev <= in_x`, moves to RUN and pushes nothing.
  - RUN: an accepted beat pushes `in_x - prev - 1` into the FIFO, loads `prev <= in_x` and stays in RUN.
- Arithmetic: 32-bit modulo 2^32. Wrap-around is normal and is never flagged.
- `resync` high at an edge:
  - state goes to SEED;
  - `prev` is unchanged;
  - FIFO contents and `dec_count` are retained.
- `in_ready = !full && !resync`, combinational from registered FIFO occupancy and the `resync` pin. No beat is accepted while `resync` is high.
- `in_ready` ignores a same-cycle pop: no push is allowed while full, even if the head is leaving.
- FIFO:
  - a push and a pop in the same cycle are both performed; occupancy is unchanged.
  - in SEED, an accepted beat never pushes.
- `dec_count` increments on every push and holds at `2^CNT_W-1`.
- `out_a` is the registered head entry. Its value is don't-care when `out_valid` is 0, but the bench checks it as 0 after reset.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state goes to SEED;
  - `prev`, FIFO pointers, storage and `dec_count` go to 0;
  - `out_valid` is 0, `out_a` is 0, `in_ready` is 1 (with `resync` low).
- Latency: a RUN beat accepted at edge N sets `out_valid` in the cycle after edge N, with `out_a` equal to its result if the FIFO was empty.
- Throughput: one beat per cycle in each direction when not full.
- Full boundary: `in_ready` is 0 from the cycle after the push that fills the FIFO, and returns to 1 the cycle after the first pop.
- Empty boundary: a pop of the last entry drops `out_valid` after that edge, unless a push happens at the same edge.
- Reset mid-operation: all state is lost immediately, and the next accepted beat after `rst_n` rises is a seed.
- `in_x` and `out_ready` have no combinational path to `out_a`.

## Configuration
- `FOO_DECODE_TRACE_EN`:
  - Defined: each push prints `"%m: decoded a = %0d"` via `$display`.
  - Defined: each entry into SEED caused by `resync` prints `"%m: resync"`.
  - Defined: an `initial` print `"Starting up: %m"` and a `final` print `"All done: %m"` are emitted.
  - Undefined: no display or `initial`/`final` statements are compiled. The logic is otherwise identical.

## Test plan
- Basic decode: after reset, feed `in_x` = 0, 6, 12, 18 with `out_ready`=1.
  - Expect `out_a` = 5, 5, 5, each one cycle after acceptance.
  - Expect `dec_count` = 3 and no output for the seed beat.
- Wrap-around: seed 0xFFFFFFFE, then `in_x` = 0x00000003 → `out_a` = 4.
- Zero operand: seed 100, then `in_x` = 101 → `out_a` = 0.
- Backpressure, `DEPTH`=4, `out_ready`=0: seed plus 5 RUN beats offered.
  - `in_ready` drops after the 4th push and the 5th beat is held.
  - Raising `out_ready` for one cycle pops the first value, and the 5th beat is accepted one cycle later.
- Resync: stream 0, 6, 12, then pulse `resync`, then `in_x` = 1000, 1010.
  - Outputs are 5, 5, 9 (1010 − 1000 − 1).
  - The 1000 beat produces no output, and `in_ready` is 0 during the pulse.
- Reset mid-stream: with 2 entries queued, pulse `rst_n` low between edges.
  - `out_valid` is immediately 0 and `dec_count` is 0.
  - The next beat, 50, is treated as a seed, so 50 then 60 → `out_a` = 9.
